alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU (InputA/InputB/OP/ControlFlags in; Out/Zero/Negative back) between two requesters: port 0, the main datapath, and port 1, a helper/microcode sequencer. It uses a valid/ready request handshake and round-robin arbitration. The ALU inputs come from registers, and results and flags are captured into a response register. The block sits between the requesters and the ALU instance in the top level.

## Interface
Parameters:
- W, 8, data width of operands and result
- OPW, 4, ALU opcode width
- CFW, 3, ALU ControlFlags width

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Req0Valid, Req1Valid  in  1 each  request present on port n
- Req0A, Req1A  in  W each  operand A for port n
- Req0B, Req1B  in  W each  operand B for port n
- Req0OP, Req1OP  in  OPW each  ALU opcode for port n
- Req0CF, Req1CF  in  CFW each  ALU ControlFlags for port n
- Req0Ready, Req1Ready  out  1 each  request accepted this cycle when Valid&&Ready
- Resp0Valid, Resp1Valid  out  1 each  one-cycle result strobe for port n
- RespData  out  W  registered ALU result (shared by both ports)
- RespZero, RespNegative  out  1 each  registered ALU flags
- AluInputA, AluInputB  out  W each  to ALU InputA/InputB (registered)
- AluOP  out  OPW  to ALU OP (registered)
- AluControlFlags  out  CFW  to ALU ControlFlags (registered)
- AluOut  in  W  from ALU Out
- AluZero, AluNegative  in  1 each  from ALU Zero/Negative

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC on any accepted request.
  - EXEC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Only one operation is outstanding at a time. Both Ready outputs are 0 in EXEC and RESP.
- Arbitration happens in IDLE and is combinational on Valid:
  - Only one port valid: that port gets Ready=1.
  - Both ports valid: the port not equal to LastGrant gets Ready=1 and the other gets 0.
- Ready may depend combinationally on Valid. A requester holds Valid and its payload stable until it sees Ready=1.
- On accept:
  - The granted payload is latched into AluInputA/AluInputB/AluOP/AluControlFlags.
  - GrantId and LastGrant are set to the granted port.
- In EXEC, the ALU output is settled. At the end of EXEC, AluOut/AluZero/AluNegative are captured into RespData/RespZero/RespNegative.
- In RESP, Resp[GrantId]Valid=1 for exactly one cycle and the other Resp valid stays 0.
- RespData and the flags hold their value until the next capture.
- The ALU operand registers hold their last value after completion; they are not cleared in IDLE.
- The block does not check or alter the width or arithmetic of results. The result is whatever the ALU produces, e.g. an 8-bit wrap on add.

## Timing
- Reset values:
  - state=IDLE, LastGrant=1 (so port 0 wins the first contention), GrantId=0.
  - All Alu* outputs =0, RespData=0, RespZero=0, RespNegative=0, Resp0Valid=Resp1Valid=0.
  - Ready follows Valid in IDLE from the first cycle after reset.
- Latency: request accepted at edge N. AluInput* become valid after edge N. Result is captured at edge N+1. RespNValid is high between edges N+1 and N+2. State returns to IDLE at edge N+2.
- Throughput: a new request is accepted at edge N+3 at the earliest, so one operation per 3 cycles.
- Reset asserted in EXEC or RESP:
  - The in-flight operation is dropped with no Resp strobe.
  - All registers return to reset values on that edge.
  - A request pending during reset is not accepted (Ready=0 while Reset=1).
- Valid deasserted while Ready=0: no effect.
- Back-to-back contention: with both ports continuously valid, grants alternate 0,1,0,1…

## Test plan
- After Reset, port 0 sends A=0x1B, B=0x0B, OP=0111 (add):
  - Req0Ready=1 in cycle 0, AluOP=0111 in cycle 1.
  - Resp0Valid=1 in cycle 2 with RespData=0x26, RespZero=0, RespNegative=0.
  - Resp1Valid stays 0.
- Port 1 sends A=0x00, B=0x00, OP=0111 → Resp1Valid pulse with RespData=0x00 and RespZero=1.
- Port 0 sends A=0x01, B=0x03, OP=1000 (sub) → RespData=0xFE and RespNegative=1. Both Ready outputs are 0 during EXEC and RESP.
- Both ports held valid (port 0 add 0x02+0x03, port 1 shift OP=1100 on A=0xF8, B=0x03) starting from reset:
  - Grant order is 0, 1, 0, 1.
  - Resp0 data is 0x05 each time.
  - Resp strobes are 3 cycles apart.
- Reset asserted during EXEC of a port 1 request: no Resp1Valid, all outputs return to 0 on the next edge, and the next contention grants port 0 first.
- Port 0 Valid held with the payload changing after the handshake: only the payload present at the accepting edge is executed.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the main datapath (port 0)
// and a helper sequencer (port 1). Requests use a valid/ready handshake with
// round-robin arbitration. One operation is in flight at a time. Each operation
// takes three cycles: accept in IDLE, the ALU settles in EXEC, and the response
// strobe fires in RESP.
module alu_arbiter #(
    parameter int W   = 8,
    parameter int OPW = 4,
    parameter int CFW = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Req0Valid,
    input  logic           Req1Valid,
    input  logic [W-1:0]   Req0A,
    input  logic [W-1:0]   Req1A,
    input  logic [W-1:0]   Req0B,
    input  logic [W-1:0]   Req1B,
    input  logic [OPW-1:0] Req0OP,
    input  logic [OPW-1:0] Req1OP,
    input  logic [CFW-1:0] Req0CF,
    input  logic [CFW-1:0] Req1CF,
    output logic           Req0Ready,
    output logic           Req1Ready,
    output logic           Resp0Valid,
    output logic           Resp1Valid,
    output logic [W-1:0]   RespData,
    output logic           RespZero,
    output logic           RespNegative,
    output logic [W-1:0]   AluInputA,
    output logic [W-1:0]   AluInputB,
    output logic [OPW-1:0] AluOP,
    output logic [CFW-1:0] AluControlFlags,
    input  logic [W-1:0]   AluOut,
    input  logic           AluZero,
    input  logic           AluNegative
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         next_state_s;

    // One-hot grant for this cycle: bit 0 is port 0 and bit 1 is port 1.
    logic [1:0]     grant_s;
    logic           accept_s;
    logic           grant_port_s;

    logic           last_grant_r;
    logic           grant_id_r;

    logic [W-1:0]   sel_a_s;
    logic [W-1:0]   sel_b_s;
    logic [OPW-1:0] sel_op_s;
    logic [CFW-1:0] sel_cf_s;

    logic [W-1:0]   alu_a_r;
    logic [W-1:0]   alu_b_r;
    logic [OPW-1:0] alu_op_r;
    logic [CFW-1:0] alu_cf_r;

    logic [W-1:0]   resp_data_r;
    logic           resp_zero_r;
    logic           resp_neg_r;
    logic           resp0_valid_r;
    logic           resp1_valid_r;

    // Round-robin choice between the two ports. When only one port is valid,
    // that port wins. When both are valid, the port that did not win last
    // time wins.
    function automatic logic [1:0] arbitrate(input logic v0, input logic v1,
                                             input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (v0 && v1) begin
            if (last) begin
                g = 2'b01;
            end else begin
                g = 2'b10;
            end
        end else if (v0) begin
            g = 2'b01;
        end else if (v1) begin
            g = 2'b10;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    // Next-state logic and the combinational grant. Ready is raised only in
    // IDLE and only while Reset is low.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 2'b00;
        case (state_r)
            IDLE: begin
                if (Reset) begin
                    grant_s = 2'b00;
                end else begin
                    grant_s = arbitrate(Req0Valid, Req1Valid, last_grant_r);
                end
                if (grant_s != 2'b00) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: begin
                next_state_s = RESP;
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign accept_s     = grant_s[0] | grant_s[1];
    assign grant_port_s = grant_s[1];
    assign Req0Ready    = grant_s[0];
    assign Req1Ready    = grant_s[1];

    // Select the payload of the granted port so it can be latched.
    always_comb begin
        sel_a_s  = Req0A;
        sel_b_s  = Req0B;
        sel_op_s = Req0OP;
        sel_cf_s = Req0CF;
        if (grant_port_s) begin
            sel_a_s  = Req1A;
            sel_b_s  = Req1B;
            sel_op_s = Req1OP;
            sel_cf_s = Req1CF;
        end else begin
            sel_a_s  = Req0A;
            sel_b_s  = Req0B;
            sel_op_s = Req0OP;
            sel_cf_s = Req0CF;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Grant bookkeeping. LastGrant resets to 1 so port 0 wins the first contention.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
        end else if (accept_s) begin
            last_grant_r <= grant_port_s;
            grant_id_r   <= grant_port_s;
        end else begin
            last_grant_r <= last_grant_r;
            grant_id_r   <= grant_id_r;
        end
    end

    // ALU operand registers. They load on accept and otherwise hold, so the
    // ALU inputs stay stable after the operation completes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            alu_a_r  <= {W{1'b0}};
            alu_b_r  <= {W{1'b0}};
            alu_op_r <= {OPW{1'b0}};
            alu_cf_r <= {CFW{1'b0}};
        end else if (accept_s) begin
            alu_a_r  <= sel_a_s;
            alu_b_r  <= sel_b_s;
            alu_op_r <= sel_op_s;
            alu_cf_r <= sel_cf_s;
        end else begin
            alu_a_r  <= alu_a_r;
            alu_b_r  <= alu_b_r;
            alu_op_r <= alu_op_r;
            alu_cf_r <= alu_cf_r;
        end
    end

    // Capture the settled ALU result at the end of EXEC. It holds until the
    // next capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            resp_data_r <= {W{1'b0}};
            resp_zero_r <= 1'b0;
            resp_neg_r  <= 1'b0;
        end else if (state_r == EXEC) begin
            resp_data_r <= AluOut;
            resp_zero_r <= AluZero;
            resp_neg_r  <= AluNegative;
        end else begin
            resp_data_r <= resp_data_r;
            resp_zero_r <= resp_zero_r;
            resp_neg_r  <= resp_neg_r;
        end
    end

    // One-cycle response strobe for the granted port. It is high during RESP.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
        end else if (state_r == EXEC) begin
            resp0_valid_r <= ~grant_id_r;
            resp1_valid_r <= grant_id_r;
        end else begin
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
        end
    end

    assign AluInputA       = alu_a_r;
    assign AluInputB       = alu_b_r;
    assign AluOP           = alu_op_r;
    assign AluControlFlags = alu_cf_r;
    assign RespData        = resp_data_r;
    assign RespZero        = resp_zero_r;
    assign RespNegative    = resp_neg_r;
    assign Resp0Valid      = resp0_valid_r;
    assign Resp1Valid      = resp1_valid_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It combines a table of single operations with
// hand-written multi-cycle sequences and a randomized run. The randomized run
// is checked against a cycle-count reference model. The ALU is modelled
// behaviourally inside the bench.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
    logic [3:0] op0 = 4'h0, op1 = 4'h0;
    logic [2:0] cf0 = 3'h0, cf1 = 3'h0;
    logic       r0, r1, rv0, rv1, rz, rn;
    logic [7:0] rdata, ain_a, ain_b, alu_out;
    logic [3:0] aop;
    logic [2:0] acf;
    logic       alu_z, alu_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: add, sub, shift-left by b[2:0], otherwise a ^ b ^ cf.
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input logic [2:0] cf);
        logic [7:0] o;
        case (op)
            4'b0111: o = a + b;
            4'b1000: o = a - b;
            4'b1100: o = a << b[2:0];
            default: o = a ^ b ^ {5'b00000, cf};
        endcase
        return {o[7], (o == 8'h00), o};
    endfunction

    assign {alu_n, alu_z, alu_out} = alu_fn(ain_a, ain_b, aop, acf);

    alu_arbiter #(.W(8), .OPW(4), .CFW(3)) dut (
        .Clk(clk), .Reset(rst),
        .Req0Valid(v0), .Req1Valid(v1),
        .Req0A(a0), .Req1A(a1), .Req0B(b0), .Req1B(b1),
        .Req0OP(op0), .Req1OP(op1), .Req0CF(cf0), .Req1CF(cf1),
        .Req0Ready(r0), .Req1Ready(r1),
        .Resp0Valid(rv0), .Resp1Valid(rv1),
        .RespData(rdata), .RespZero(rz), .RespNegative(rn),
        .AluInputA(ain_a), .AluInputB(ain_b), .AluOP(aop), .AluControlFlags(acf),
        .AluOut(alu_out), .AluZero(alu_z), .AluNegative(alu_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_aluA"}, ain_a, 8'h00);
        chk({tag, "_aluB"}, ain_b, 8'h00);
        chk({tag, "_aluOP"}, aop, 4'h0);
        chk({tag, "_aluCF"}, acf, 3'h0);
        chk({tag, "_rdata"}, rdata, 8'h00);
        chk({tag, "_rflags"}, {rz, rn}, 2'b00);
        chk({tag, "_rvalid"}, {rv0, rv1}, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic v0, v1;
        logic [7:0] a0, b0; logic [3:0] op0;
        logic [7:0] a1, b1; logic [3:0] op1;
        logic g;
        logic [7:0] d; logic z, n;
    } vec_t;

    vec_t vecs[8];

    // Run one operation from IDLE and check accept, EXEC and RESP.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        @(negedge clk);
        v0 = v.v0; a0 = v.a0; b0 = v.b0; op0 = v.op0; cf0 = 3'h0;
        v1 = v.v1; a1 = v.a1; b1 = v.b1; op1 = v.op1; cf1 = 3'h0;
        #1;
        chk({t, "_ready"}, {r1, r0}, v.g ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        chk({t, "_exec_ready"}, {r1, r0}, 2'b00);
        chk({t, "_exec_op"}, aop, v.g ? v.op1 : v.op0);
        chk({t, "_exec_a"}, ain_a, v.g ? v.a1 : v.a0);
        chk({t, "_exec_rv"}, {rv1, rv0}, 2'b00);
        @(posedge clk); #1;
        chk({t, "_resp_ready"}, {r1, r0}, 2'b00);
        chk({t, "_resp_rv"}, {rv1, rv0}, v.g ? 2'b10 : 2'b01);
        chk({t, "_resp_data"}, rdata, v.d);
        chk({t, "_resp_flags"}, {rz, rn}, {v.z, v.n});
        v0 = 1'b0; v1 = 1'b0;
        @(posedge clk);
    endtask

    // Randomized reference-model state
    int         busy;
    logic       mlast, mgid, acc0_prev, acc1_prev, er0, er1;
    logic [7:0] ma, mb, mdata;
    logic [3:0] mop;
    logic [2:0] mcf;
    logic       mz, mn;

    initial begin
        int last_cyc, nstrobe, cyc_seen;
        logic [3:0] order;

        vecs[0] = '{1'b1, 1'b0, 8'h1B, 8'h0B, 4'b0111, 8'h00, 8'h00, 4'h0, 1'b0, 8'h26, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4'b0111, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h01, 8'h03, 4'b1000, 8'h00, 8'h00, 4'h0, 1'b0, 8'hFE, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 8'h02, 8'h03, 4'b0111, 8'hF8, 8'h03, 4'b1100, 1'b1, 8'hC0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 8'h02, 8'h03, 4'b0111, 8'hF8, 8'h03, 4'b1100, 1'b0, 8'h05, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h02, 8'h03, 4'b0111, 8'hF8, 8'h03, 4'b1100, 1'b1, 8'hC0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h01, 4'b0111, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h40, 8'h01, 4'b0111, 8'h05, 8'h05, 4'b1000, 1'b1, 8'h00, 1'b1, 1'b0};

        // Reset state
        do_reset();
        #1;
        check_all_zero("reset");
        chk("reset_ready_idle", {r1, r0}, 2'b00);

        // Table of single operations
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Back-to-back contention from reset
        do_reset();
        a0 = 8'h02; b0 = 8'h03; op0 = 4'b0111; cf0 = 3'h0;
        a1 = 8'hF8; b1 = 8'h03; op1 = 4'b1100; cf1 = 3'h0;
        v0 = 1'b1; v1 = 1'b1;
        nstrobe = 0; last_cyc = -1; order = 4'h0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (rv0 || rv1) begin
                if (nstrobe < 4) order[nstrobe] = rv1;
                if (rv0) chk("contend_resp0_data", rdata, 8'h05);
                else chk("contend_resp1_data", rdata, 8'hC0);
                chk("contend_one_strobe", {rv1, rv0} == 2'b11, 1'b0);
                if (last_cyc >= 0) chk("contend_spacing", c - last_cyc, 3);
                last_cyc = c;
                nstrobe++;
            end
            @(negedge clk);
        end
        chk("contend_strobes_seen", nstrobe >= 4, 1'b1);
        chk("contend_order", order, 4'b1010);
        v0 = 1'b0; v1 = 1'b0;

        // Reset during EXEC of a port 1 request
        do_reset();
        a1 = 8'h11; b1 = 8'h22; op1 = 4'b0111; cf1 = 3'h5; v1 = 1'b1;
        #1;
        chk("rst_exec_accept", r1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready_low", r1, 1'b0);
        cyc_seen = 0;
        @(posedge clk); #1;
        check_all_zero("rst_exec");
        @(negedge clk);
        #1;
        chk("rst_held_ready_low", {r1, r0}, 2'b00);
        rst = 1'b0; v0 = 1'b1;
        a0 = 8'h02; b0 = 8'h03; op0 = 4'b0111; cf0 = 3'h0;
        #1;
        chk("rst_first_contention", {r1, r0}, 2'b01);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        if (rv1) cyc_seen++;
        @(posedge clk); #1;
        if (rv1) cyc_seen++;
        chk("rst_no_resp1", cyc_seen, 0);
        chk("rst_after_resp0", {rv0, rdata}, {1'b1, 8'h05});
        @(posedge clk);

        // Payload changes after the handshake while Valid stays high
        @(negedge clk);
        v0 = 1'b1; a0 = 8'h1B; b0 = 8'h0B; op0 = 4'b0111; cf0 = 3'h0;
        @(posedge clk); #1;
        a0 = 8'h10; b0 = 8'h10; op0 = 4'b1000;
        chk("payload_latched_a", ain_a, 8'h1B);
        chk("payload_latched_op", aop, 4'b0111);
        @(posedge clk); #1;
        chk("payload_resp", {rv0, rdata}, {1'b1, 8'h26});
        v0 = 1'b0;
        @(posedge clk); #1;
        chk("payload_hold_data", rdata, 8'h26);

        // Randomized stimulus against the reference model
        do_reset();
        busy = 0; mlast = 1'b1; mgid = 1'b0; acc0_prev = 1'b0; acc1_prev = 1'b0;
        ma = 8'h00; mb = 8'h00; mop = 4'h0; mcf = 3'h0; mdata = 8'h00; mz = 1'b0; mn = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c != 0) @(negedge clk);
            if (!v0 || acc0_prev) begin
                v0 = 1'($urandom_range(0, 1));
                a0 = 8'($urandom); b0 = 8'($urandom);
                op0 = 4'($urandom); cf0 = 3'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                v0 = 1'b0;
            end else begin
                v0 = v0;
            end
            if (!v1 || acc1_prev) begin
                v1 = 1'($urandom_range(0, 1));
                a1 = 8'($urandom); b1 = 8'($urandom);
                op1 = 4'($urandom); cf1 = 3'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                v1 = 1'b0;
            end else begin
                v1 = v1;
            end
            #1;
            er0 = (busy == 0) && v0 && (!v1 || mlast);
            er1 = (busy == 0) && v1 && (!v0 || !mlast);
            chk("rand_ready", {r1, r0}, {er1, er0});
            chk("rand_rvalid", {rv1, rv0}, {(busy == 1) && mgid, (busy == 1) && !mgid});
            chk("rand_resp", {rdata, rz, rn}, {mdata, mz, mn});
            chk("rand_alu_in", {ain_a, ain_b, aop, acf}, {ma, mb, mop, mcf});
            acc0_prev = er0; acc1_prev = er1;
            if (er0 || er1) begin
                busy = 2; mgid = er1; mlast = er1;
                ma = er1 ? a1 : a0; mb = er1 ? b1 : b0;
                mop = er1 ? op1 : op0; mcf = er1 ? cf1 : cf0;
            end else if (busy == 2) begin
                {mn, mz, mdata} = alu_fn(ma, mb, mop, mcf);
                busy = 1;
            end else if (busy == 1) begin
                busy = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
